bird_spawner: RTL

- Owns the position and alive state of every bird. Advances the birds once per movement tick, retires birds that escape off the right edge or are shot, and respawns them at the left edge with a pseudo-random altitude.
- Sits directly upstream of the bird draw sequencer. The draw sequencer reads the current and previous x, plus y, for one bird at a time through an indexed read port. It uses previous x for erase and current x for draw.
- Replaces free-running per-bird x counters and simulation-only random y.

---
 rtl/duck_hunt_pkg.sv | 25 ++
 rtl/lfsr16.sv | 29 ++
 rtl/bird_spawner.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/duck_hunt_pkg.sv
// Shared Duck Hunt constants, LFSR helpers and spawner FSM encoding.
// Used by bird_spawner and lfsr16.
package duck_hunt_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int MAX_BIRDS = 8;

    // Fibonacci taps 16,14,13,11 expressed on a right-shifting register
    localparam logic [15:0] LFSR_TAPS         = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } spawn_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free running, loads seed on reset.
// Shared by the spawner and later hunter/laser randomness.
module lfsr16
    import duck_hunt_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = lfsr_next(state_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bird_spawner.sv
// Bird position/alive owner: one bird per cycle per movement pass.
// Define SPAWN_STAGGER_EN to limit respawns to one bird per pass.
module bird_spawner
    import duck_hunt_pkg::*;
#(
    parameter int          NUM_BIRDS = 7,
    parameter int          X_START   = 5,
    parameter int          X_MAX     = 159,
    parameter int          Y_MIN     = 10,
    parameter int          Y_MAX     = 109,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 move_tick,
    input  logic [NUM_BIRDS-1:0] bird_on,
    input  logic                 kill_valid,
    input  logic [2:0]           kill_idx,
    input  logic [2:0]           rd_idx,
    output logic [X_W-1:0]       rd_x,
    output logic [X_W-1:0]       rd_prev_x,
    output logic [Y_W-1:0]       rd_y,
    output logic                 rd_alive,
    output logic                 busy,
    output logic                 pass_done,
    output logic [7:0]           escaped
);

    localparam logic [X_W-1:0] X_START_V = X_W'(X_START);
    localparam logic [X_W-1:0] X_MAX_V   = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MIN_V   = Y_W'(Y_MIN);
    localparam logic [7:0]     Y_MIN_8   = 8'(Y_MIN);
    localparam logic [7:0]     Y_MAX_8   = 8'(Y_MAX);
    localparam logic [7:0]     Y_RANGE   = 8'(Y_MAX - Y_MIN + 1);

    spawn_state_e state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [7:0]   esc_q, esc_d;

    logic [NUM_BIRDS-1:0]     alive_q, alive_d;
    logic [NUM_BIRDS-1:0]     held_q, held_d;
    logic [NUM_BIRDS*X_W-1:0] x_q, x_d;
    logic [NUM_BIRDS*X_W-1:0] px_q, px_d;
    logic [NUM_BIRDS*Y_W-1:0] y_q, y_d;

`ifdef SPAWN_STAGGER_EN
    logic spawned_q, spawned_d;
`endif

    logic [15:0]    lfsr;
    logic [7:0]     v;
    logic [7:0]     ysum;
    logic [Y_W-1:0] spawn_y;
    logic [X_W-1:0] cur_x;
    logic [X_W-1:0] nxt_x;
    logic           kill_hit;
    logic           self_kill;
    logic           spawn_ok;

    lfsr16 u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .seed   (LFSR_SEED),
        .state  (lfsr)
    );

    // Fold 0..127 into the spawn band with a single subtract
    always_comb begin
        v = 8'(lfsr & 16'h007F);
        if (v >= Y_RANGE) begin
            v = v - Y_RANGE;
        end
        ysum = Y_MIN_8 + v;
        if (ysum > Y_MAX_8) begin
            ysum = Y_MAX_8;
        end
        spawn_y = Y_W'(ysum);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        esc_d   = esc_q;
        alive_d = alive_q;
        held_d  = held_q;
        x_d     = x_q;
        px_d    = px_q;
        y_d     = y_q;
`ifdef SPAWN_STAGGER_EN
        spawned_d = spawned_q;
        spawn_ok  = !spawned_q;
`else
        spawn_ok  = 1'b1;
`endif
        cur_x     = x_q[int'(idx_q)*X_W +: X_W];
        nxt_x     = cur_x + X_W'(1);
        kill_hit  = kill_valid && (int'(kill_idx) < NUM_BIRDS);
        self_kill = kill_hit && (kill_idx == idx_q);

        unique case (state_q)
            IDLE: begin
                if (move_tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                    held_d  = '0;
`ifdef SPAWN_STAGGER_EN
                    spawned_d = 1'b0;
`endif
                end
            end
            UPDATE: begin
                if (!self_kill) begin
                    if (!bird_on[idx_q]) begin
                        alive_d[idx_q] = 1'b0;
                    end else if (!alive_q[idx_q]) begin
                        // held: killed earlier in this pass, waits a pass
                        if (!held_q[idx_q] && spawn_ok) begin
                            alive_d[idx_q]                  = 1'b1;
                            x_d[int'(idx_q)*X_W +: X_W]  = X_START_V;
                            px_d[int'(idx_q)*X_W +: X_W] = X_START_V;
                            y_d[int'(idx_q)*Y_W +: Y_W]  = spawn_y;
`ifdef SPAWN_STAGGER_EN
                            spawned_d = 1'b1;
`endif
                        end
                    end else begin
                        px_d[int'(idx_q)*X_W +: X_W] = cur_x;
                        x_d[int'(idx_q)*X_W +: X_W]  = nxt_x;
                        if (nxt_x == X_MAX_V) begin
                            alive_d[idx_q] = 1'b0;
                            if (esc_q != 8'hFF) begin
                                esc_d = esc_q + 8'd1;
                            end
                        end
                    end
                end
                if (int'(idx_q) == NUM_BIRDS - 1) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Kill lands last so it overrides any move or spawn
        if (kill_hit) begin
            alive_d[kill_idx] = 1'b0;
            if (state_q == UPDATE) begin
                held_d[kill_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            esc_q   <= '0;
            alive_q <= '0;
            held_q  <= '0;
            x_q     <= {NUM_BIRDS{X_START_V}};
            px_q    <= {NUM_BIRDS{X_START_V}};
            y_q     <= {NUM_BIRDS{Y_MIN_V}};
`ifdef SPAWN_STAGGER_EN
            spawned_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            esc_q   <= esc_d;
            alive_q <= alive_d;
            held_q  <= held_d;
            x_q     <= x_d;
            px_q    <= px_d;
            y_q     <= y_d;
`ifdef SPAWN_STAGGER_EN
            spawned_q <= spawned_d;
`endif
        end
    end

    always_comb begin
        rd_x      = '0;
        rd_prev_x = '0;
        rd_y      = '0;
        rd_alive  = 1'b0;
        if (int'(rd_idx) < NUM_BIRDS) begin
            rd_x      = x_q[int'(rd_idx)*X_W +: X_W];
            rd_prev_x = px_q[int'(rd_idx)*X_W +: X_W];
            rd_y      = y_q[int'(rd_idx)*Y_W +: Y_W];
            rd_alive  = alive_q[rd_idx];
        end
    end

    assign busy      = (state_q != IDLE);
    assign pass_done = (state_q == DONE);
    assign escaped   = esc_q;

endmodule
